// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// Holds the register-zero constant and the buffered writeback entry layout.
package wb_write_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of pipeline-side signals around the writeback arbiter.
// master = pipeline/testbench side, slave = arbiter side.
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              md_issue;
  logic [ADDR_W-1:0] md_issue_reg;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_reg;
  logic [DATA_W-1:0] md_data;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic              stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_reg, alu_data, md_issue, md_issue_reg,
    output md_valid, md_reg, md_data, read_reg1, read_reg2,
    input  md_ready, stall, RegWrite, write_reg, write_data, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, md_issue, md_issue_reg,
    input  md_valid, md_reg, md_data, read_reg1, read_reg2,
    output md_ready, stall, RegWrite, write_reg, write_data, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Small synchronous FIFO for multiply/divide results awaiting the write port.
// Head is read straight from the storage array so it can be popped the same cycle it is chosen.
module wb_result_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  wb_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU results win, buffered mult/div results fill idle cycles.
// Also tracks registers with an outstanding mult/div result and stalls decode on them.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  wb_write_arbiter_if.slave bus
);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int NUM_REGS = 1 << ADDR_W;

  wb_entry_t         head;
  wb_entry_t         push_entry;
  logic              full;
  logic              empty;
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [NUM_REGS-1:0] busy;

  logic              reg_write_reg;
  logic [ADDR_W-1:0] write_reg_reg;
  logic [DATA_W-1:0] write_data_reg;

  // Ready depends only on state (and reset), never on md_valid.
  assign bus.md_ready = !reset && !full;
  assign accept       = bus.md_valid && bus.md_ready;
  assign pop          = !bus.alu_valid && !empty;
  assign push_entry   = '{addr: bus.md_reg, data: bus.md_data};

  wb_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .head       (head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else if (bus.alu_valid) begin
      reg_write_reg  <= (bus.alu_reg != REG_ZERO);
      write_reg_reg  <= bus.alu_reg;
      write_data_reg <= bus.alu_data;
    end else if (pop) begin
      reg_write_reg  <= (head.addr != REG_ZERO);
      write_reg_reg  <= head.addr;
      write_data_reg <= head.data;
    end else begin
      reg_write_reg  <= 1'b0;
    end
  end

  // Register 0 is never busy, which also masks it out of the stall check.
  assign busy[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      always_ff @(posedge clock) begin
        if (reset) begin
          busy[gi] <= 1'b0;
        end else if (bus.md_issue && bus.md_issue_reg == ADDR_W'(gi)) begin
          busy[gi] <= 1'b1;
        end else if (pop && head.addr == ADDR_W'(gi)) begin
          busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign bus.stall      = busy[bus.read_reg1] || busy[bus.read_reg2];
  assign bus.RegWrite   = reg_write_reg;
  assign bus.write_reg  = write_reg_reg;
  assign bus.write_data = write_data_reg;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: table vectors, directed corner sequences,
// and a cycle model whose mult/div result queue is compared against every write.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  wb_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  wb_entry_t   mq[$];
  bit          mbusy[32];
  bit          exp_we   = 1'b0;
  logic [4:0]  exp_reg  = '0;
  logic [31:0] exp_data = '0;
  bit          mon_en   = 1'b0;

  always @(posedge clock) begin : model
    wb_entry_t e;
    int sz0;
    if (reset) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      exp_we = 1'b0;
    end else begin
      sz0    = mq.size();
      exp_we = 1'b0;
      if (bus.alu_valid) begin
        exp_we   = (bus.alu_reg != 5'd0);
        exp_reg  = bus.alu_reg;
        exp_data = bus.alu_data;
      end else if (sz0 > 0) begin
        e = mq.pop_front();
        mbusy[e.addr] = 1'b0;
        exp_we   = (e.addr != 5'd0);
        exp_reg  = e.addr;
        exp_data = e.data;
      end
      if (bus.md_valid && sz0 < DEPTH)
        mq.push_back('{addr: bus.md_reg, data: bus.md_data});
      if (bus.md_issue && bus.md_issue_reg != 5'd0)
        mbusy[bus.md_issue_reg] = 1'b1;
    end
  end

  always @(negedge clock) begin : monitor
    if (mon_en) begin
      chk("mon_regwrite", bus.RegWrite, exp_we);
      if (exp_we && bus.RegWrite) begin
        chk("mon_write_reg", bus.write_reg, exp_reg);
        chk("mon_write_data", bus.write_data, exp_data);
      end
      chk("mon_fifo_count", bus.fifo_count, mq.size());
      chk("mon_md_ready", bus.md_ready, (!reset && mq.size() < DEPTH));
      chk("mon_stall", bus.stall,
          ((bus.read_reg1 != 0 && mbusy[bus.read_reg1]) ||
           (bus.read_reg2 != 0 && mbusy[bus.read_reg2])));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid    = 1'b0;
    bus.alu_reg      = '0;
    bus.alu_data     = '0;
    bus.md_issue     = 1'b0;
    bus.md_issue_reg = '0;
    bus.md_valid     = 1'b0;
    bus.md_reg       = '0;
    bus.md_data      = '0;
    bus.read_reg1    = '0;
    bus.read_reg2    = '0;
  endtask

  typedef struct {
    bit          alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    bit          exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc;
    int acc5_cycle;
    bit rdy;
    bit drained;

    vecs[0] = '{1'b1, 5'd21, 32'd17,         1'b1, 5'd21, 32'd17};
    vecs[1] = '{1'b1, 5'd0,  32'h55,         1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 5'd5,  32'h1234,       1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd1,  32'h0,          1'b1, 5'd1,  32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'hDEAD_BEEF,  1'b1, 5'd7,  32'hDEAD_BEEF};

    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_md_ready_low", bus.md_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_md_ready_release", bus.md_ready, 1);
    mon_en = 1'b1;

    // Table-driven ALU path, one-cycle latency
    for (int i = 0; i < 6; i++) begin
      bus.alu_valid = vecs[i].alu_valid;
      bus.alu_reg   = vecs[i].alu_reg;
      bus.alu_data  = vecs[i].alu_data;
      tick();
      bus.alu_valid = 1'b0;
      chk($sformatf("vec%0d_regwrite", i), bus.RegWrite, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk($sformatf("vec%0d_write_reg", i), bus.write_reg, vecs[i].exp_reg);
        chk($sformatf("vec%0d_write_data", i), bus.write_data, vecs[i].exp_data);
      end
    end
    tick();

    // Priority: FIFO holds (4,0xBB), then ALU (3,0xAA) wins
    bus.md_valid = 1'b1; bus.md_reg = 5'd4; bus.md_data = 32'hBB;
    tick();
    bus.md_valid = 1'b0;
    chk("prio_count_after_push", bus.fifo_count, 1);
    chk("prio_no_write_same_cycle", bus.RegWrite, 0);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'hAA;
    tick();
    bus.alu_valid = 1'b0;
    chk("prio_alu_we", bus.RegWrite, 1);
    chk("prio_alu_reg", bus.write_reg, 3);
    chk("prio_alu_data", bus.write_data, 32'hAA);
    chk("prio_count_held", bus.fifo_count, 1);
    tick();
    chk("prio_md_we", bus.RegWrite, 1);
    chk("prio_md_reg", bus.write_reg, 4);
    chk("prio_md_data", bus.write_data, 32'hBB);
    chk("prio_count_empty", bus.fifo_count, 0);
    tick();
    chk("prio_idle", bus.RegWrite, 0);

    // Back-pressure: ALU busy 6 cycles, 5 results offered
    acc = 0;
    acc5_cycle = -1;
    for (int c = 0; c < 30; c++) begin
      bus.alu_valid = (c < 6);
      bus.alu_reg   = 5'(10 + c);
      bus.alu_data  = 32'h100 + c;
      bus.md_valid  = (acc < 5);
      bus.md_reg    = 5'(16 + acc);
      bus.md_data   = 32'h200 + acc;
      @(negedge clock);
      rdy = bus.md_ready;
      if (c == 4) chk("bp_ready_low_when_full", rdy, 0);
      tick();
      if (bus.md_valid && rdy) begin
        acc++;
        if (acc == 5) acc5_cycle = c;
      end
      if (c == 5) chk("bp_accepts_during_alu", acc, 4);
      if (acc == 5 && c >= 6) break;
    end
    idle_inputs();
    chk("bp_fifth_accept_cycle", acc5_cycle, 7);
    drained = 1'b0;
    for (int w = 0; w < 12; w++) begin
      tick();
      if (bus.fifo_count == 0 && !bus.RegWrite) begin
        drained = 1'b1;
        break;
      end
    end
    chk("bp_drained", drained, 1);

    // Scoreboard: issue reg 22, stall until its result is written
    bus.md_issue = 1'b1; bus.md_issue_reg = 5'd22;
    bus.read_reg1 = 5'd22; bus.read_reg2 = 5'd0;
    #1;
    chk("sb_stall_before_issue_edge", bus.stall, 0);
    tick();
    bus.md_issue = 1'b0;
    #1;
    chk("sb_stall_set", bus.stall, 1);
    bus.read_reg1 = 5'd0;
    #1;
    chk("sb_reg0_never_stalls", bus.stall, 0);
    bus.read_reg2 = 5'd22;
    #1;
    chk("sb_stall_via_reg2", bus.stall, 1);
    bus.read_reg1 = 5'd22; bus.read_reg2 = 5'd0;
    tick();
    chk("sb_stall_held", bus.stall, 1);
    bus.md_valid = 1'b1; bus.md_reg = 5'd22; bus.md_data = 32'd29;
    tick();
    bus.md_valid = 1'b0;
    chk("sb_stall_while_buffered", bus.stall, 1);
    chk("sb_count_buffered", bus.fifo_count, 1);
    tick();
    chk("sb_write_we", bus.RegWrite, 1);
    chk("sb_write_reg", bus.write_reg, 22);
    chk("sb_write_data", bus.write_data, 29);
    chk("sb_stall_cleared", bus.stall, 0);
    tick();
    idle_inputs();

    // Register 0: result consumed silently, issue does not mark busy
    bus.md_valid = 1'b1; bus.md_reg = 5'd0; bus.md_data = 32'h77;
    bus.md_issue = 1'b1; bus.md_issue_reg = 5'd0;
    tick();
    idle_inputs();
    chk("r0_count_pushed", bus.fifo_count, 1);
    chk("r0_stall", bus.stall, 0);
    tick();
    chk("r0_count_popped", bus.fifo_count, 0);
    chk("r0_no_write", bus.RegWrite, 0);
    tick();

    // Reset mid-burst: 3 buffered entries and a busy register discarded
    bus.md_issue = 1'b1; bus.md_issue_reg = 5'd9;
    bus.read_reg1 = 5'd9;
    for (int k = 0; k < 3; k++) begin
      bus.alu_valid = 1'b1; bus.alu_reg = 5'(2 + k); bus.alu_data = 32'h300 + k;
      bus.md_valid  = 1'b1; bus.md_reg  = 5'(24 + k); bus.md_data = 32'h400 + k;
      tick();
      bus.md_issue = 1'b0;
    end
    bus.alu_valid = 1'b0; bus.md_valid = 1'b0;
    chk("mrst_count_before", bus.fifo_count, 3);
    chk("mrst_busy_before", bus.stall, 1);
    reset = 1'b1;
    #1;
    chk("mrst_ready_in_reset", bus.md_ready, 0);
    tick();
    chk("mrst_count", bus.fifo_count, 0);
    chk("mrst_regwrite", bus.RegWrite, 0);
    chk("mrst_busy_clear", bus.stall, 0);
    reset = 1'b0;
    #1;
    chk("mrst_ready_after", bus.md_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mrst_no_stale_%0d", k), bus.RegWrite, 0);
    end

    idle_inputs();
    repeat (3) tick();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 register file write port (RegWrite / write_reg / write_data).
- Merges two writeback sources into the single port:
  - the single-cycle ALU/load path;
  - the multi-cycle multiply/divide unit, which arrives out of band over a valid/ready handshake and is buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding multi-cycle results and raises stall when decode reads a busy register.

Parameters:
- FIFO_DEPTH, 4, entries in the multiply/divide result buffer (power of 2, >= 2).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU/load result present this cycle; cannot be back-pressured.
- alu_reg  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- md_issue  in  1  mult/div op issued this cycle; marks its destination busy.
- md_issue_reg  in  ADDR_W  destination of the issued mult/div op.
- md_valid  in  1  mult/div result offered.
- md_ready  out  1  buffer can accept a result.
- md_reg  in  ADDR_W  mult/div result destination.
- md_data  in  DATA_W  mult/div result.
- read_reg1  in  ADDR_W  decode source register 1.
- read_reg2  in  ADDR_W  decode source register 2.
- stall  out  1  decode must hold (a source register is busy).
- RegWrite  out  1  register file write enable.
- write_reg  out  ADDR_W  register file write address.
- write_data  out  DATA_W  register file write data.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy, for debug and verification.

Behaviour:
- Reset (synchronous, on the clock edge while reset=1):
  - RegWrite=0, write_reg=0, write_data=0.
  - FIFO empty, fifo_count=0, all busy bits clear.
  - md_ready=0 while reset is high; md_ready=1 on the first cycle after release.
  - A reset mid-operation discards buffered results and all scoreboard state.
- Handshake:
  - A result is accepted when md_valid && md_ready at a rising edge.
  - md_ready = !full; it is registered-safe, with no dependency on md_valid.
- Arbitration, evaluated every cycle:
  - The ALU has absolute priority.
  - If alu_valid: the next edge drives RegWrite=1, write_reg=alu_reg, write_data=alu_data.
  - Else if FIFO non-empty: the next edge drives the FIFO head and pops it.
  - Else RegWrite=0.
  - The output registers give one cycle of latency from source to the RegWrite pulse.
- Register 0:
  - Any selected write with destination 0 produces RegWrite=0, but the entry is still consumed (popped).
  - md_issue to register 0 never sets busy.
- Simultaneous accept and pop: occupancy is unchanged. A full FIFO may accept in a cycle it pops only if md_ready was high; md_ready does not look ahead.
- Empty FIFO with an accept and no ALU write: the entry is written on the following cycle. There is no same-cycle bypass.
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH; fifo_count saturates at neither end (overflow and underflow are impossible by the handshake).
- Scoreboard:
  - busy[r] is set at the edge where md_issue=1 with md_issue_reg=r (r != 0).
  - busy[r] is cleared at the edge where a FIFO entry with destination r is popped.
  - If set and clear hit the same register in the same cycle, set wins.
- Stall (combinational): stall = (read_reg1 != 0 && busy[read_reg1]) || (read_reg2 != 0 && busy[read_reg2]).
- Ordering between writers:
  - Upstream guarantees it never issues a second mult/div to an already-busy register.
  - Upstream resolves ALU-vs-mult/div write-after-write ordering via stall; this block does not reorder writes.

Decomposition:
- Shared package holds REG_ZERO=5'd0, DATA_W and ADDR_W, and the writeback-entry struct {reg addr, data}.
- One natural sub-module, wb_result_fifo: parameterised synchronous FIFO exposing push, pop, full, empty, count and head.
- Arbitration, scoreboard and output registers stay in the top level.

Test Plan:
- Reset mid-burst: push 3 entries, assert reset for 1 cycle -> fifo_count=0, RegWrite=0, all busy clear, md_ready=1 on the next cycle, no stale writes.
- ALU only: alu_valid with reg 21, data 17 -> exactly one cycle later RegWrite=1, write_reg=21, write_data=17.
- Priority: alu_valid (reg 3, data 0xAA) and FIFO holding (reg 4, data 0xBB) -> reg 3 written first, reg 4 on the next cycle, fifo_count goes 1 then 0.
- Back-pressure: alu_valid held high for 6 cycles while 5 results are offered with FIFO_DEPTH=4 -> md_ready=0 after 4 accepts, 5th accepted only after drain begins, all 5 written in order.
- Scoreboard: md_issue reg 22, then read_reg1=22 -> stall=1 until the cycle after (reg 22, data 29) is written, then 0; read_reg2=0 never stalls.
- Register 0: mult/div result to reg 0 -> popped, fifo_count decrements, RegWrite stays 0; md_issue reg 0 leaves stall=0.
